// File: rtl/posit_adder_arbiter.sv
// rtl/posit_adder_arbiter.sv - two-requester round-robin arbiter in front of an external combinational posit adder
module posit_adder_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_in1,
    input  logic [N-1:0] req0_in2,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_in1,
    input  logic [N-1:0] req1_in2,
    output logic         req1_ready,
    output logic         resp0_valid,
    output logic         resp1_valid,
    output logic [N-1:0] resp_data,
    input  logic         resp0_ready,
    input  logic         resp1_ready,
    output logic [N-1:0] add_in1,
    output logic [N-1:0] add_in2,
    input  logic [N-1:0] add_out,
    output logic         busy,
    output logic         owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] op1_q, op1_d;
    logic [N-1:0] op2_q, op2_d;
    logic [N-1:0] result_q, result_d;
    logic         owner_q, owner_d;
    logic         last_q, last_d;
    logic         grant0, grant1;
    logic         owner_ready;

    // Arbitration: only in IDLE and out of reset; on contention the requester not granted last wins
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && (state_q == IDLE)) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_q;
                grant1 = ~last_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign owner_ready = owner_q ? resp1_ready : resp0_ready;

    // Next-state logic: latch operands on handshake, capture the sum in CALC, wait for the owner in RESP
    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        result_d = result_q;
        owner_d  = owner_q;
        last_d   = last_q;
        case (state_q)
            IDLE: begin
                if (grant0) begin
                    op1_d   = req0_in1;
                    op2_d   = req0_in2;
                    owner_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = CALC;
                end else if (grant1) begin
                    op1_d   = req1_in1;
                    op2_d   = req1_in2;
                    owner_d = 1'b1;
                    last_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                result_d = add_out;
                state_d  = RESP;
            end
            RESP: begin
                if (owner_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; last-grant resets to 1 so requester 0 wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            result_q <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            result_q <= result_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign add_in1     = op1_q;
    assign add_in2     = op2_q;
    assign resp_data   = result_q;
    assign resp0_valid = (state_q == RESP) && !owner_q;
    assign resp1_valid = (state_q == RESP) && owner_q;
    assign busy        = (state_q != IDLE);
    assign owner       = owner_q;

endmodule

// File: tb/tb_posit_adder_arbiter.sv
// tb/tb_posit_adder_arbiter.sv - directed table-driven bench for posit_adder_arbiter
module tb_posit_adder_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic       req0_ready, req1_ready;
    logic       resp0_valid, resp1_valid;
    logic [7:0] resp_data;
    logic       resp0_ready, resp1_ready;
    logic [7:0] add_in1, add_in2, add_out;
    logic       busy, owner;
    logic       ovr_en;
    logic [7:0] ovr_val;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign add_out = ovr_en ? ovr_val : 8'(add_in1 + add_in2);

    posit_adder_arbiter #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_data(resp_data),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .add_in1(add_in1), .add_in2(add_in2), .add_out(add_out),
        .busy(busy), .owner(owner)
    );

    typedef struct {
        logic       v0;
        logic [7:0] a0, b0;
        logic       v1;
        logic [7:0] a1, b1;
        logic       ovr;
        logic [7:0] ovr_val;
        logic       g;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                                input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                                input logic ovr, input logic [7:0] ov,
                                input logic g, input logic [7:0] exp);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.b0 = b0;
        v.v1 = v1; v.a1 = a1; v.b1 = b1;
        v.ovr = ovr; v.ovr_val = ov;
        v.g = g; v.exp = exp;
        return v;
    endfunction

    initial begin
        // contention from reset release, then singles, pass-through and round-robin continuation
        vecs[0] = mk(1, 8'h10, 8'h01, 1, 8'h20, 8'h02, 0, 8'h00, 0, 8'h11);
        vecs[1] = mk(1, 8'h10, 8'h01, 1, 8'h20, 8'h02, 0, 8'h00, 1, 8'h22);
        vecs[2] = mk(1, 8'h10, 8'h01, 1, 8'h20, 8'h02, 0, 8'h00, 0, 8'h11);
        vecs[3] = mk(1, 8'h10, 8'h01, 1, 8'h20, 8'h02, 0, 8'h00, 1, 8'h22);
        vecs[4] = mk(1, 8'h40, 8'h05, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h45);
        vecs[5] = mk(0, 8'h00, 8'h00, 1, 8'h80, 8'h00, 1, 8'h80, 1, 8'h80);
        vecs[6] = mk(1, 8'hFF, 8'h01, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00);
        vecs[7] = mk(1, 8'h01, 8'h02, 1, 8'h7F, 8'h01, 0, 8'h00, 1, 8'h80);
        vecs[8] = mk(1, 8'h01, 8'h02, 1, 8'h7F, 8'h01, 0, 8'h00, 0, 8'h03);

        rst_n = 1'b0;
        ovr_en = 1'b0; ovr_val = 8'h00;
        req0_valid = 1'b1; req0_in1 = 8'h10; req0_in2 = 8'h01;
        req1_valid = 1'b1; req1_in1 = 8'h20; req1_in2 = 8'h02;
        resp0_ready = 1'b1; resp1_ready = 1'b1;

        @(negedge clk); @(negedge clk); #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_resp_valid", {resp0_valid, resp1_valid}, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_add_in", {add_in1, add_in2}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            req0_valid = vecs[i].v0; req0_in1 = vecs[i].a0; req0_in2 = vecs[i].b0;
            req1_valid = vecs[i].v1; req1_in1 = vecs[i].a1; req1_in2 = vecs[i].b1;
            ovr_en = vecs[i].ovr; ovr_val = vecs[i].ovr_val;
            #1;
            chk($sformatf("v%0d_ready", i), {req1_ready, req0_ready}, vecs[i].g ? 2'b10 : 2'b01);
            @(negedge clk); #1;
            chk($sformatf("v%0d_calc_busy", i), busy, 1);
            chk($sformatf("v%0d_calc_ready", i), {req1_ready, req0_ready}, 0);
            chk($sformatf("v%0d_calc_resp", i), {resp1_valid, resp0_valid}, 0);
            chk($sformatf("v%0d_add_in", i), {add_in1, add_in2},
                vecs[i].g ? {vecs[i].a1, vecs[i].b1} : {vecs[i].a0, vecs[i].b0});
            req0_valid = 1'b0; req1_valid = 1'b0;
            @(negedge clk); #1;
            chk($sformatf("v%0d_resp_valid", i), {resp1_valid, resp0_valid}, vecs[i].g ? 2'b10 : 2'b01);
            chk($sformatf("v%0d_resp_data", i), resp_data, vecs[i].exp);
            chk($sformatf("v%0d_owner", i), owner, vecs[i].g);
            @(negedge clk); #1;
            chk($sformatf("v%0d_idle", i), busy, 0);
            chk($sformatf("v%0d_idle_resp", i), {resp1_valid, resp0_valid}, 0);
        end
        ovr_en = 1'b0;

        // backpressure on requester 1 while requester 0 waits; non-owner resp0_ready stays high
        req1_valid = 1'b1; req1_in1 = 8'h33; req1_in2 = 8'h11;
        resp1_ready = 1'b0; resp0_ready = 1'b1;
        #1;
        chk("bp_grant", {req1_ready, req0_ready}, 2'b10);
        @(negedge clk); #1;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_in1 = 8'h55; req0_in2 = 8'h01;
        @(negedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_resp1_valid", k), resp1_valid, 1);
            chk($sformatf("bp%0d_resp0_valid", k), resp0_valid, 0);
            chk($sformatf("bp%0d_data", k), resp_data, 8'h44);
            chk($sformatf("bp%0d_req0_ready", k), req0_ready, 0);
            @(negedge clk); #1;
        end
        resp1_ready = 1'b1; req0_valid = 1'b0;
        @(negedge clk); #1;
        chk("bp_idle", busy, 0);
        chk("bp_resp1_drop", resp1_valid, 0);
        chk("bp_data_hold", resp_data, 8'h44);

        // reset asserted during CALC drops the transaction
        req0_valid = 1'b1; req0_in1 = 8'h12; req0_in2 = 8'h34;
        @(negedge clk); #1;
        chk("mr_calc_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_add_in", {add_in1, add_in2}, 0);
        chk("mr_resp_data", resp_data, 0);
        chk("mr_owner", owner, 0);
        chk("mr_ready", {req1_ready, req0_ready}, 0);
        req0_valid = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk($sformatf("mr%0d_no_resp", k), {resp1_valid, resp0_valid, busy}, 0);
        end
        req0_valid = 1'b1; req0_in1 = 8'h10; req0_in2 = 8'h01;
        req1_valid = 1'b1; req1_in1 = 8'h20; req1_in2 = 8'h02;
        #1;
        chk("mr_regrant", {req1_ready, req0_ready}, 2'b01);
        @(negedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
        chk("mr_resp_valid", {resp1_valid, resp0_valid}, 2'b01);
        chk("mr_resp_data2", resp_data, 8'h11);
        @(negedge clk); #1;
        chk("mr_final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
